// File: rtl/regist_pkg.sv
// Shared definitions for the 4-bit function register and its command sequencer.
package regist_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_HOLD  = 3'b000;
  localparam opcode_t OP_RESET = 3'b001;
  localparam opcode_t OP_LOAD  = 3'b010;
  localparam opcode_t OP_SHL   = 3'b011;
  localparam opcode_t OP_SHR   = 3'b100;

  typedef enum logic {IDLE, EXEC} state_t;

  function automatic logic op_is_legal(opcode_t op);
    return op <= OP_SHR;
  endfunction

  function automatic logic op_is_shift(opcode_t op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/regist_sequencer_if.sv
// Operator command channel into the sequencer: valid/ready handshake plus payload.
interface regist_sequencer_if
  import regist_pkg::*;
#(
  parameter int COUNT_W = 3
);

  logic               cmd_valid;
  logic               cmd_ready;
  opcode_t            cmd_op;
  logic [3:0]         cmd_data;
  logic [COUNT_W-1:0] cmd_count;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  cmd_count,
    output cmd_ready
  );

endinterface

// File: rtl/regist_cmd_fifo.sv
// Small synchronous FIFO holding packed commands; clear empties it in one edge.
module regist_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count alone decides which entries are meaningful.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/regist_sequencer.sv
// Feeds the function register one operation per clock from a queue of operator
// commands, expanding shift repeat counts and idling the register with HOLD.
module regist_sequencer
  import regist_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int COUNT_W = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  regist_sequencer_if.slave   cmd,
  input  logic                flush,
  output logic [2:0]          funcao,
  output logic [3:0]          entrada,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int WIDTH = 3 + 4 + COUNT_W;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0]   fifo_head;
  opcode_t            head_op;
  logic [3:0]         head_data;
  logic [COUNT_W-1:0] head_count, head_eff_count;

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] remaining_q, remaining_d;
  opcode_t            funcao_q, funcao_d;
  logic [3:0]         entrada_q, entrada_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               last_cycle;

  regist_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (flush),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_data ({cmd.cmd_op, cmd.cmd_data, cmd.cmd_count}),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign cmd.cmd_ready = !fifo_full;
  assign fifo_push     = cmd.cmd_valid && !fifo_full && !flush;

  assign head_op    = opcode_t'(fifo_head[WIDTH-1 -: 3]);
  assign head_data  = fifo_head[COUNT_W +: 4];
  assign head_count = fifo_head[COUNT_W-1:0];

  // Only shifts repeat; a zero count still issues once.
  assign head_eff_count = (op_is_shift(head_op) && (head_count != '0)) ? head_count : COUNT_W'(1);

  // Popping on the final issue cycle chains commands without a HOLD bubble.
  assign last_cycle = (state_q == EXEC) && (remaining_q == COUNT_W'(1));
  assign fifo_pop   = !flush && !fifo_empty && ((state_q == IDLE) || last_cycle);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    funcao_d    = funcao_q;
    entrada_d   = entrada_q;
    done_d      = 1'b0;
    err_d       = err_q;
    if (flush) begin
      state_d     = IDLE;
      remaining_d = '0;
      funcao_d    = OP_HOLD;
      entrada_d   = '0;
    end else if (fifo_pop) begin
      state_d     = EXEC;
      remaining_d = head_eff_count;
      funcao_d    = op_is_legal(head_op) ? head_op : OP_HOLD;
      entrada_d   = (head_op == OP_LOAD) ? head_data : 4'd0;
      done_d      = (head_eff_count == COUNT_W'(1));
      if (!op_is_legal(head_op)) begin
        err_d = 1'b1;
      end
    end else if ((state_q == IDLE) || last_cycle) begin
      state_d     = IDLE;
      remaining_d = '0;
      funcao_d    = OP_HOLD;
      entrada_d   = '0;
    end else begin
      remaining_d = remaining_q - COUNT_W'(1);
      done_d      = (remaining_q == COUNT_W'(2));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      funcao_q    <= OP_HOLD;
      entrada_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      funcao_q    <= funcao_d;
      entrada_q   <= entrada_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign funcao  = funcao_q;
  assign entrada = entrada_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q == EXEC) || !fifo_empty;

endmodule
